txtsu_collector: RTL and testbench

- Downstream consumer of the TX timestamp buses of a pair of endpoints (nic side of ITXTSU_Bus).
- Arbitrates between endpoint A and endpoint B timestamp reports, acknowledges each one, and buffers entries in a FIFO.
- Presents buffered entries, oldest first, to the minic/CPU readout logic.
- Never stalls an endpoint. On overflow it drops the entry and counts the loss.

---
 rtl/txtsu_pkg.sv | 17 +
 rtl/txtsu_fifo.sv | 65 ++++++
 rtl/txtsu_collector.sv | 134 +++++++++++++
 tb/tb_txtsu_collector.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txtsu_pkg.sv
// Shared types for the TX timestamp collector: the buffered entry layout and arbiter FSM states.
package txtsu_pkg;

   localparam int c_txtsu_port_id_width  = 5;
   localparam int c_txtsu_frame_id_width = 16;
   localparam int c_txtsu_ts_width       = 32;

   typedef struct packed {
      logic                              src;
      logic [c_txtsu_port_id_width-1:0]  port_id;
      logic [c_txtsu_frame_id_width-1:0] frame_id;
      logic [c_txtsu_ts_width-1:0]       ts;
   } t_txtsu_entry;

   typedef enum logic {IDLE, ACK} t_txtsu_state;

endpackage

// File: rtl/txtsu_fifo.sv
// Show-ahead synchronous FIFO of timestamp entries; head is on data_o with no read latency.
// Push while full is accepted only if a pop happens at the same edge; pop while empty is ignored.
module txtsu_fifo
   import txtsu_pkg::*;
#(
   parameter int g_depth = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  t_txtsu_entry               data_i,
   input  logic                       pop_i,
   output t_txtsu_entry               data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(g_depth):0]   count_o
);

   localparam int            c_aw   = $clog2(g_depth);
   localparam logic [c_aw:0] c_full = (c_aw+1)'(g_depth);

   logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
   logic [c_aw:0]   count_q, count_d;
   t_txtsu_entry    mem_q [g_depth];
   logic            empty, full, do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == c_full);
   assign do_pop  = pop_i && !empty;
   // A pop on a full FIFO frees the slot the concurrent push needs.
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + 1'b1;
      else if (do_pop && !do_push)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push)
         mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign full_o  = full;
   assign empty_o = empty;
   assign count_o = count_q;

endmodule

// File: rtl/txtsu_collector.sv
// Round-robin collector of endpoint A/B TX timestamps into a show-ahead FIFO; ack one cycle after grant.
// Endpoints are never stalled: on a full FIFO the entry is acked, dropped and counted.
module txtsu_collector
   import txtsu_pkg::*;
#(
   parameter int g_fifo_depth     = 16,
   parameter int g_drop_cnt_width = 16
) (
   input  logic                              clk_sys_i,
   input  logic                              rst_i,
   input  logic                              a_valid_i,
   output logic                              a_ack_o,
   input  logic [c_txtsu_port_id_width-1:0]  a_port_id_i,
   input  logic [c_txtsu_frame_id_width-1:0] a_frame_id_i,
   input  logic [c_txtsu_ts_width-1:0]       a_ts_i,
   input  logic                              b_valid_i,
   output logic                              b_ack_o,
   input  logic [c_txtsu_port_id_width-1:0]  b_port_id_i,
   input  logic [c_txtsu_frame_id_width-1:0] b_frame_id_i,
   input  logic [c_txtsu_ts_width-1:0]       b_ts_i,
   output logic                              out_valid_o,
   input  logic                              out_pop_i,
   output logic                              out_src_o,
   output logic [c_txtsu_port_id_width-1:0]  out_port_id_o,
   output logic [c_txtsu_frame_id_width-1:0] out_frame_id_o,
   output logic [c_txtsu_ts_width-1:0]       out_ts_o,
   output logic [$clog2(g_fifo_depth):0]     fill_o,
   output logic                              overflow_o,
   output logic [g_drop_cnt_width-1:0]       drop_cnt_o,
   input  logic                              clr_stat_i
);

   t_txtsu_state                state_q;
   t_txtsu_entry                cap_q, head;
   logic                        ptr_q, hold_a_q, hold_b_q, a_ack_q, b_ack_q;
   logic                        elig_a, elig_b, grant_a, grant_b;
   logic                        push, drop, fifo_full, fifo_empty;
   logic                        overflow_q, overflow_d;
   logic [g_drop_cnt_width-1:0] drop_cnt_q, drop_cnt_d;

   assign elig_a  = a_valid_i && !hold_a_q;
   assign elig_b  = b_valid_i && !hold_b_q;
   assign grant_a = elig_a && (!elig_b || !ptr_q);
   assign grant_b = elig_b && !grant_a;
   assign push    = (state_q == ACK);
   assign drop    = push && fifo_full && !out_pop_i;

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         hold_a_q <= 1'b0;
         hold_b_q <= 1'b0;
         a_ack_q  <= 1'b0;
         b_ack_q  <= 1'b0;
         cap_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               hold_a_q <= 1'b0;
               hold_b_q <= 1'b0;
               if (grant_a) begin
                  cap_q   <= '{src: 1'b0, port_id: a_port_id_i, frame_id: a_frame_id_i, ts: a_ts_i};
                  a_ack_q <= 1'b1;
                  state_q <= ACK;
               end else if (grant_b) begin
                  cap_q   <= '{src: 1'b1, port_id: b_port_id_i, frame_id: b_frame_id_i, ts: b_ts_i};
                  b_ack_q <= 1'b1;
                  state_q <= ACK;
               end
            end
            ACK: begin
               // Mask the served port for one cycle so a late valid deassert is not re-captured.
               a_ack_q  <= 1'b0;
               b_ack_q  <= 1'b0;
               hold_a_q <= !cap_q.src;
               hold_b_q <= cap_q.src;
               ptr_q    <= !cap_q.src;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Clear beats the increment, but a same-edge drop still leaves overflow set.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (clr_stat_i) begin
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end else if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
      if (drop)
         overflow_d = 1'b1;
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   txtsu_fifo #(
      .g_depth (g_fifo_depth)
   ) u_fifo (
      .clk_i   (clk_sys_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (cap_q),
      .pop_i   (out_pop_i),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fill_o)
   );

   assign a_ack_o        = a_ack_q;
   assign b_ack_o        = b_ack_q;
   assign out_valid_o    = !fifo_empty;
   assign out_src_o      = head.src;
   assign out_port_id_o  = head.port_id;
   assign out_frame_id_o = head.frame_id;
   assign out_ts_o       = head.ts;
   assign overflow_o     = overflow_q;
   assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_txtsu_collector.sv
// Bench for txtsu_collector: directed scenarios plus a randomized run against a queue-based model.
module tb_txtsu_collector;
   import txtsu_pkg::*;

   localparam int DEPTH = 16;
   localparam int DW    = 3;
   localparam int DMAX  = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ack, b_ack;
   logic [4:0]  a_port = '0, b_port = '0;
   logic [15:0] a_frame = '0, b_frame = '0;
   logic [31:0] a_ts = '0, b_ts = '0;
   logic        out_valid, out_pop = 1'b0, out_src;
   logic [4:0]  out_port;
   logic [15:0] out_frame;
   logic [31:0] out_ts;
   logic [4:0]  fill;
   logic        overflow;
   logic [DW-1:0] drop_cnt;
   logic        clr = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   txtsu_collector #(
      .g_fifo_depth     (DEPTH),
      .g_drop_cnt_width (DW)
   ) dut (
      .clk_sys_i      (clk),
      .rst_i          (rst),
      .a_valid_i      (a_valid),
      .a_ack_o        (a_ack),
      .a_port_id_i    (a_port),
      .a_frame_id_i   (a_frame),
      .a_ts_i         (a_ts),
      .b_valid_i      (b_valid),
      .b_ack_o        (b_ack),
      .b_port_id_i    (b_port),
      .b_frame_id_i   (b_frame),
      .b_ts_i         (b_ts),
      .out_valid_o    (out_valid),
      .out_pop_i      (out_pop),
      .out_src_o      (out_src),
      .out_port_id_o  (out_port),
      .out_frame_id_o (out_frame),
      .out_ts_o       (out_ts),
      .fill_o         (fill),
      .overflow_o     (overflow),
      .drop_cnt_o     (drop_cnt),
      .clr_stat_i     (clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise one port's request, hold it until its ack; returns in the ack cycle (lat=-1 on timeout).
   task automatic send(input logic b, input logic [15:0] fid, input logic [31:0] ts,
                       input logic [4:0] pid, output int lat);
      lat = -1;
      if (!b) begin a_valid = 1'b1; a_port = pid; a_frame = fid; a_ts = ts; end
      else    begin b_valid = 1'b1; b_port = pid; b_frame = fid; b_ts = ts; end
      for (int i = 0; i < 12; i++) begin
         tick();
         if ((!b && a_ack) || (b && b_ack)) begin
            lat = i;
            break;
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic both(input logic [15:0] fa, input logic [15:0] fb, output int ta, output int tbv);
      a_valid = 1'b1; a_port = 5'd1; a_frame = fa; a_ts = {16'hA000, fa};
      b_valid = 1'b1; b_port = 5'd2; b_frame = fb; b_ts = {16'hB000, fb};
      ta = -1;
      tbv = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (a_ack && ta < 0)  begin ta = i;  a_valid = 1'b0; end
         if (b_ack && tbv < 0) begin tbv = i; b_valid = 1'b0; end
         if (ta >= 0 && tbv >= 0) break;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic drain();
      out_pop = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!out_valid) break;
         tick();
      end
      out_pop = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
      tick();
      tick();
      total++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", {a_ack, b_ack}); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if ({out_src, out_port, out_frame, out_ts} !== 54'd0) begin bad++; $display("FAIL reset_out_data: got %h want 0", {out_src, out_port, out_frame, out_ts}); end
      total++; if (fill !== 5'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", fill); end
      total++; if ({overflow, drop_cnt} !== 4'd0) begin bad++; $display("FAIL reset_stats: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
      a_valid = 1'b0; b_valid = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_a_only();
      int lat, extra;
      send(1'b0, 16'h1234, 32'hDEADBEEF, 5'd3, lat);
      total++; if (lat !== 0) begin bad++; $display("FAIL a_only_ack_latency: got %0d want 0", lat); end
      tick();
      total++; if ({out_valid, out_src, out_port, out_frame, out_ts} !== {1'b1, 1'b0, 5'd3, 16'h1234, 32'hDEADBEEF}) begin
         bad++; $display("FAIL a_only_head: got v=%b src=%b pid=%0d fid=%h ts=%h want 1/0/3/1234/deadbeef", out_valid, out_src, out_port, out_frame, out_ts);
      end
      total++; if (fill !== 5'd1) begin bad++; $display("FAIL a_only_fill: got %0d want 1", fill); end
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         if (a_ack || b_ack) extra++;
         tick();
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL a_only_extra_acks: got %0d want 0", extra); end
      drain();
   endtask

   task automatic test_round_robin();
      int ta, tbv, lat;
      pulse_reset();
      both(16'h0011, 16'h0022, ta, tbv);
      total++; if (ta !== 0 || tbv !== 2) begin bad++; $display("FAIL rr_first_order: got a@%0d b@%0d want a@0 b@2", ta, tbv); end
      tick();
      total++; if (fill !== 5'd2) begin bad++; $display("FAIL rr_fill: got %0d want 2", fill); end
      total++; if ({out_src, out_port, out_frame} !== {1'b0, 5'd1, 16'h0011}) begin bad++; $display("FAIL rr_head_a: got src=%b pid=%0d fid=%h want 0/1/0011", out_src, out_port, out_frame); end
      out_pop = 1'b1; tick(); out_pop = 1'b0;
      total++; if ({out_src, out_port, out_frame, out_ts} !== {1'b1, 5'd2, 16'h0022, 32'hB000_0022}) begin bad++; $display("FAIL rr_head_b: got src=%b pid=%0d fid=%h ts=%h want 1/2/0022/b0000022", out_src, out_port, out_frame, out_ts); end
      drain();
      send(1'b0, 16'h0033, 32'h0, 5'd4, lat);
      tick();
      drain();
      both(16'h0044, 16'h0055, ta, tbv);
      total++; if (tbv !== 0 || ta !== 2) begin bad++; $display("FAIL rr_second_order: got a@%0d b@%0d want b@0 a@2", ta, tbv); end
      tick();
      total++; if ({out_src, out_frame} !== {1'b1, 16'h0055}) begin bad++; $display("FAIL rr_second_head: got src=%b fid=%h want 1/0055", out_src, out_frame); end
      drain();
   endtask

   task automatic test_late_deassert();
      int acks;
      acks = 0;
      a_valid = 1'b1; a_port = 5'd7; a_frame = 16'h0077; a_ts = 32'h7777;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (a_ack) begin acks++; break; end
      end
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (a_ack) acks++;
         tick();
      end
      total++; if (acks !== 1) begin bad++; $display("FAIL late_ack_count: got %0d want 1", acks); end
      total++; if (fill !== 5'd1) begin bad++; $display("FAIL late_fill: got %0d want 1", fill); end
      drain();
   endtask

   task automatic test_overflow();
      int lat, acks;
      pulse_reset();
      acks = 0;
      for (int i = 0; i < 18; i++) begin
         send(1'b0, 16'(i + 1), $urandom, 5'(i), lat);
         if (lat >= 0) acks++;
      end
      tick();
      total++; if (acks !== 18) begin bad++; $display("FAIL ovf_acks: got %0d want 18", acks); end
      total++; if (fill !== 5'd16) begin bad++; $display("FAIL ovf_fill: got %0d want 16", fill); end
      total++; if ({overflow, drop_cnt} !== {1'b1, 3'd2}) begin bad++; $display("FAIL ovf_stats: got ovf=%b drop=%0d want 1/2", overflow, drop_cnt); end
      total++; if (out_frame !== 16'd1) begin bad++; $display("FAIL ovf_head: got fid=%h want 0001", out_frame); end
      clr = 1'b1; tick(); clr = 1'b0;
      total++; if ({overflow, drop_cnt} !== 4'd0) begin bad++; $display("FAIL ovf_clear: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
   endtask

   task automatic test_full_pop();
      int lat;
      send(1'b0, 16'h0100, 32'h100, 5'd9, lat);
      out_pop = 1'b1; tick(); out_pop = 1'b0;
      total++; if (fill !== 5'd16) begin bad++; $display("FAIL fullpop_fill: got %0d want 16", fill); end
      total++; if (out_frame !== 16'd2) begin bad++; $display("FAIL fullpop_head: got fid=%h want 0002", out_frame); end
      total++; if ({overflow, drop_cnt} !== 4'd0) begin bad++; $display("FAIL fullpop_stats: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
   endtask

   task automatic test_saturation();
      int lat;
      for (int i = 0; i < 9; i++)
         send(1'b0, 16'(16'h0200 + i), $urandom, 5'd1, lat);
      tick();
      total++; if ({overflow, drop_cnt} !== {1'b1, 3'd7}) begin bad++; $display("FAIL sat_stats: got ovf=%b drop=%0d want 1/7", overflow, drop_cnt); end
      send(1'b0, 16'h0300, 32'h0, 5'd1, lat);
      clr = 1'b1; tick(); clr = 1'b0;
      total++; if ({overflow, drop_cnt} !== {1'b1, 3'd0}) begin bad++; $display("FAIL clr_vs_drop: got ovf=%b drop=%0d want 1/0", overflow, drop_cnt); end
   endtask

   task automatic test_reset_mid_ack();
      int lat, ta, tbv;
      send(1'b0, 16'h0400, 32'h0, 5'd2, lat);
      rst = 1'b1;
      tick();
      total++; if (a_ack !== 1'b0) begin bad++; $display("FAIL midack_ack: got %b want 0", a_ack); end
      total++; if ({out_valid, fill, overflow, drop_cnt} !== 10'd0) begin bad++; $display("FAIL midack_state: got v=%b fill=%0d ovf=%b drop=%0d want all 0", out_valid, fill, overflow, drop_cnt); end
      total++; if ({out_src, out_port, out_frame, out_ts} !== 54'd0) begin bad++; $display("FAIL midack_data: got %h want 0", {out_src, out_port, out_frame, out_ts}); end
      rst = 1'b0;
      both(16'h0401, 16'h0402, ta, tbv);
      total++; if (ta !== 0 || tbv !== 2) begin bad++; $display("FAIL midack_ptr: got a@%0d b@%0d want a@0 b@2", ta, tbv); end
      tick();
      total++; if ({fill, out_frame} !== {5'd2, 16'h0401}) begin bad++; $display("FAIL midack_after: got fill=%0d fid=%h want 2/0401", fill, out_frame); end
      drain();
   endtask

   task automatic test_random();
      t_txtsu_entry q[$];
      t_txtsu_entry a_ent, b_ent;
      int  drops, exp_drop, a_late, b_late, a_wait, b_wait, pct;
      bit  a_pend, b_pend, pop;
      pulse_reset();
      drops = 0; a_late = 0; b_late = 0; a_wait = 0; b_wait = 0;
      a_pend = 1'b0; b_pend = 1'b0;
      a_ent = '0; b_ent = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         tick();
         exp_drop = (drops > DMAX) ? DMAX : drops;
         total++; if (fill !== 5'(q.size())) begin bad++; $display("FAIL rnd_fill c%0d: got %0d want %0d", cyc, fill, q.size()); end
         total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, q.size() != 0); end
         if (q.size() > 0) begin
            total++; if ({out_src, out_port, out_frame, out_ts} !== q[0]) begin bad++; $display("FAIL rnd_head c%0d: got %h want %h", cyc, {out_src, out_port, out_frame, out_ts}, q[0]); end
         end
         total++; if ({overflow, drop_cnt} !== {drops > 0, DW'(exp_drop)}) begin bad++; $display("FAIL rnd_stats c%0d: got ovf=%b drop=%0d want %b/%0d", cyc, overflow, drop_cnt, drops > 0, exp_drop); end
         total++; if (a_ack && b_ack) begin bad++; $display("FAIL rnd_dual_ack c%0d: got 11 want at most one", cyc); end
         if (a_ack) begin total++; if (!a_pend) begin bad++; $display("FAIL rnd_spurious_a c%0d: got ack want none", cyc); end end
         if (b_ack) begin total++; if (!b_pend) begin bad++; $display("FAIL rnd_spurious_b c%0d: got ack want none", cyc); end end
         if (a_pend) begin a_wait++; total++; if (a_wait > 8) begin bad++; $display("FAIL rnd_starve_a c%0d: got wait %0d want <=8", cyc, a_wait); a_pend = 1'b0; end end
         if (b_pend) begin b_wait++; total++; if (b_wait > 8) begin bad++; $display("FAIL rnd_starve_b c%0d: got wait %0d want <=8", cyc, b_wait); b_pend = 1'b0; end end

         pct = (cyc < 400) ? 20 : 75;
         pop = ($urandom_range(0, 99) < pct);
         out_pop = pop;
         if (pop && q.size() > 0) void'(q.pop_front());
         if (a_ack && a_pend) begin
            if (q.size() < DEPTH) q.push_back(a_ent); else drops++;
            a_pend = 1'b0; a_late = $urandom_range(1, 2);
         end
         if (b_ack && b_pend) begin
            if (q.size() < DEPTH) q.push_back(b_ent); else drops++;
            b_pend = 1'b0; b_late = $urandom_range(1, 2);
         end

         if (a_pend) a_valid = 1'b1;
         else if (a_late > 0) begin a_valid = 1'b1; a_late--; end
         else if ($urandom_range(0, 99) < 40) begin
            a_pend = 1'b1; a_wait = 0;
            a_ent = '{src: 1'b0, port_id: 5'($urandom), frame_id: 16'($urandom), ts: $urandom};
            a_valid = 1'b1; a_port = a_ent.port_id; a_frame = a_ent.frame_id; a_ts = a_ent.ts;
         end else a_valid = 1'b0;

         if (b_pend) b_valid = 1'b1;
         else if (b_late > 0) begin b_valid = 1'b1; b_late--; end
         else if ($urandom_range(0, 99) < 40) begin
            b_pend = 1'b1; b_wait = 0;
            b_ent = '{src: 1'b1, port_id: 5'($urandom), frame_id: 16'($urandom), ts: $urandom};
            b_valid = 1'b1; b_port = b_ent.port_id; b_frame = b_ent.frame_id; b_ts = b_ent.ts;
         end else b_valid = 1'b0;
      end
      a_valid = 1'b0; b_valid = 1'b0; out_pop = 1'b0;
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_a_only();
      test_round_robin();
      test_late_deassert();
      test_overflow();
      test_full_pop();
      test_saturation();
      test_reset_mid_ack();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
